// File: rtl/car_pkg.sv
// car_pkg: shared constants, FSM state type and command decode for the
// car command controller.
//   FRAME_HDR         : first byte of every command frame
//   CMD_*             : legal command codes (0x00..0x04)
//   MOT_*             : H-bridge {in1,in2} encodings
//   car_state_t       : frame parser states
//   decode_cmd()      : command code -> left/right H-bridge encodings
package car_pkg;

    localparam logic [7:0] FRAME_HDR  = 8'hA5;

    localparam logic [7:0] CMD_STOP   = 8'h00;
    localparam logic [7:0] CMD_FWD    = 8'h01;
    localparam logic [7:0] CMD_BACK   = 8'h02;
    localparam logic [7:0] CMD_SPIN_L = 8'h03;
    localparam logic [7:0] CMD_SPIN_R = 8'h04;

    localparam logic [1:0] MOT_FWD    = 2'b10;
    localparam logic [1:0] MOT_BACK   = 2'b01;
    localparam logic [1:0] MOT_STOP   = 2'b00;

    typedef enum logic [1:0] {
        S_HDR,
        S_CMD,
        S_SPD,
        S_CHK
    } car_state_t;

    typedef struct packed {
        logic [1:0] left;
        logic [1:0] right;
    } motor_pair_t;

    // Unknown codes decode to stop; they are rejected before use anyway.
    function automatic motor_pair_t decode_cmd(input logic [7:0] cmd);
        motor_pair_t m;
        m.left  = MOT_STOP;
        m.right = MOT_STOP;
        case (cmd)
            CMD_FWD:    begin m.left = MOT_FWD;  m.right = MOT_FWD;  end
            CMD_BACK:   begin m.left = MOT_BACK; m.right = MOT_BACK; end
            CMD_SPIN_L: begin m.left = MOT_BACK; m.right = MOT_FWD;  end
            CMD_SPIN_R: begin m.left = MOT_FWD;  m.right = MOT_BACK; end
            default:    ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/car_pwm_gen.sv
// car_pwm_gen: shared motor-enable PWM generator.
// A prescaler divides clk by PWM_PRESC+1; each prescaler wrap advances an
// 8-bit period counter. The effective duty is reloaded from duty_target only
// when the period counter wraps 255->0, so a period is never cut short.
// force_zero overrides that and clears the effective duty on the next clk.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   duty_target  in   requested duty (0..255 of 256)
//   force_zero   in   immediate stop request (one clk is enough)
//   pwm          out  pwm_cnt < effective duty
module car_pwm_gen #(
    parameter int PWM_PRESC = 49
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] duty_target,
    input  logic       force_zero,
    output logic       pwm
);

    localparam int PW = (PWM_PRESC > 0) ? $clog2(PWM_PRESC + 1) : 1;

    logic [PW-1:0] presc;
    logic [7:0]    pwm_cnt;
    logic [7:0]    duty_eff;
    logic          tick;

    assign tick = (presc == PW'(PWM_PRESC));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc    <= '0;
            pwm_cnt  <= '0;
            duty_eff <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            if (force_zero) begin
                duty_eff <= '0;
            end else if (tick && (pwm_cnt == 8'hFF)) begin
                duty_eff <= duty_target;
            end
        end
    end

    assign pwm = (pwm_cnt < duty_eff);

endmodule

// File: rtl/car_cmd_ctrl.sv
// car_cmd_ctrl: frame parser, command decode and link watchdog for the car.
// Bytes from the UART receiver form frames A5, CMD, SPD, CHK with
// CHK = CMD ^ SPD. Accepted frames set the H-bridge directions, LED and the
// PWM target duty. A gap timer drops stalled partial frames; a watchdog
// stops the car when no frame has been accepted for WDT_CYC clks.
//
// Handshake: rx_valid is a one-clk strobe qualifying rx_data; there is no
// ready/backpressure, every strobed byte is consumed in the clk it appears,
// and strobes may arrive on consecutive clks.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   rx_data      in   received byte
//   rx_valid     in   byte strobe
//   motor_l/r    out  H-bridge {in1,in2}: 10 fwd, 01 back, 00 stop
//   pwm_l/r      out  motor enable PWM (same waveform on both)
//   LED          out  CMD of last accepted frame
//   cmd_ok       out  one-clk pulse per accepted frame
//   frame_err    out  one-clk pulse on checksum, bad-cmd or gap error
//   wdt_expired  out  high while the watchdog stop is in force
//   fsm_state    out  parser state, for observation
module car_cmd_ctrl
    import car_pkg::*;
#(
    parameter int PWM_PRESC = 49,
    parameter int GAP_CYC   = 520800,
    parameter int WDT_CYC   = 62500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [1:0] motor_l,
    output logic [1:0] motor_r,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic [7:0] LED,
    output logic       cmd_ok,
    output logic       frame_err,
    output logic       wdt_expired,
    output logic [1:0] fsm_state
);

    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int WW = $clog2(WDT_CYC + 1);

    car_state_t  state, state_next;
    logic [GW-1:0] gap_cnt;
    logic [WW-1:0] wdt_cnt;
    logic [7:0]  cmd_q, spd_q, duty_target;
    logic        latch_cmd, latch_spd, chk_byte, gap_to;
    logic        accept, reject, wdt_hit, force_zero, pwm;
    motor_pair_t dec;

    // Parser next state. A strobe always beats a gap timeout in the same clk.
    always_comb begin
        state_next = state;
        latch_cmd  = 1'b0;
        latch_spd  = 1'b0;
        chk_byte   = 1'b0;
        gap_to     = 1'b0;
        if (rx_valid) begin
            case (state)
                S_HDR: if (rx_data == FRAME_HDR) state_next = S_CMD;
                S_CMD: begin latch_cmd = 1'b1; state_next = S_SPD; end
                S_SPD: begin latch_spd = 1'b1; state_next = S_CHK; end
                S_CHK: begin chk_byte  = 1'b1; state_next = S_HDR; end
                default: state_next = S_HDR;
            endcase
        end else if ((state != S_HDR) && (gap_cnt == GW'(GAP_CYC))) begin
            gap_to     = 1'b1;
            state_next = S_HDR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_HDR;
        else        state <= state_next;
    end

    assign fsm_state = state;

    assign accept     = chk_byte && (rx_data == (cmd_q ^ spd_q)) && (cmd_q <= CMD_SPIN_R);
    assign reject     = chk_byte && !accept;
    // Expiry fires once, on the clk the counter reaches WDT_CYC; an accept
    // in that clk cancels it.
    assign wdt_hit    = !accept && (wdt_cnt == WW'(WDT_CYC - 1));
    assign force_zero = (accept && (cmd_q == CMD_STOP)) || wdt_hit;
    assign dec        = decode_cmd(cmd_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt     <= '0;
            wdt_cnt     <= '0;
            cmd_q       <= '0;
            spd_q       <= '0;
            motor_l     <= MOT_STOP;
            motor_r     <= MOT_STOP;
            LED         <= '0;
            duty_target <= '0;
            cmd_ok      <= 1'b0;
            frame_err   <= 1'b0;
            wdt_expired <= 1'b0;
        end else begin
            if (rx_valid || gap_to || (state == S_HDR)) gap_cnt <= '0;
            else                                        gap_cnt <= gap_cnt + 1'b1;

            if (latch_cmd) cmd_q <= rx_data;
            if (latch_spd) spd_q <= rx_data;

            if (accept)                        wdt_cnt <= '0;
            else if (wdt_cnt != WW'(WDT_CYC))  wdt_cnt <= wdt_cnt + 1'b1;

            cmd_ok    <= accept;
            frame_err <= reject || gap_to;

            if (accept) begin
                motor_l     <= dec.left;
                motor_r     <= dec.right;
                LED         <= cmd_q;
                duty_target <= (cmd_q == CMD_STOP) ? 8'h00 : spd_q;
                wdt_expired <= 1'b0;
            end else if (wdt_hit) begin
                motor_l     <= MOT_STOP;
                motor_r     <= MOT_STOP;
                duty_target <= 8'h00;
                wdt_expired <= 1'b1;
            end
        end
    end

    car_pwm_gen #(
        .PWM_PRESC (PWM_PRESC)
    ) u_pwm (
        .clk         (clk),
        .reset       (reset),
        .duty_target (duty_target),
        .force_zero  (force_zero),
        .pwm         (pwm)
    );

    assign pwm_l = pwm;
    assign pwm_r = pwm;

endmodule

// File: tb/tb_car_cmd_ctrl.sv
module tb_car_cmd_ctrl;

  localparam int GAP = 200;
  localparam int WDT = 2000;
  localparam int W   = 15;  // {cmd_ok, frame_err, motor_l, motor_r, LED, wdt_expired}

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [1:0] motor_l, motor_r, fsm_state;
  logic       pwm_l, pwm_r, cmd_ok, frame_err, wdt_expired;
  logic [7:0] LED;

  always #4 clk = ~clk;

  car_cmd_ctrl #(.PWM_PRESC(0), .GAP_CYC(GAP), .WDT_CYC(WDT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .motor_l(motor_l), .motor_r(motor_r), .pwm_l(pwm_l), .pwm_r(pwm_r),
    .LED(LED), .cmd_ok(cmd_ok), .frame_err(frame_err),
    .wdt_expired(wdt_expired), .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (frame level) ----------------
  int         cyc = 0;       // clk edges since reset release
  int         last_acc = 0;  // cyc of the last accepted frame
  logic [1:0] m_ml = 2'b00, m_mr = 2'b00;
  logic [7:0] m_led = 8'h00, m_duty = 8'h00;
  logic       m_wdt = 1'b0;
  logic [W-1:0] exp_q[$];

  function automatic logic [3:0] mot_of(input logic [7:0] cmd);
    case (cmd)
      8'h01:   return 4'b10_10;
      8'h02:   return 4'b01_01;
      8'h03:   return 4'b01_10;
      8'h04:   return 4'b10_01;
      default: return 4'b00_00;
    endcase
  endfunction

  task automatic model_reset();
    cyc = 0; last_acc = 0;
    m_ml = 2'b00; m_mr = 2'b00; m_led = 8'h00; m_duty = 8'h00; m_wdt = 1'b0;
  endtask

  task automatic model_wdt();
    if (!m_wdt && (cyc - last_acc) >= WDT) begin
      m_wdt = 1'b1; m_ml = 2'b00; m_mr = 2'b00; m_duty = 8'h00;
    end
  endtask

  // Called right after the clk that sampled the CHK strobe.
  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] spd,
                             input logic [7:0] chk, output logic ok);
    ok = (chk == (cmd ^ spd)) && (cmd <= 8'h04);
    if (ok) begin
      last_acc = cyc; m_wdt = 1'b0;
      {m_ml, m_mr} = mot_of(cmd);
      m_led = cmd;
      m_duty = (cmd == 8'h00) ? 8'h00 : spd;
    end else begin
      model_wdt();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_data = 8'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] spd,
                            input logic [7:0] chk, output logic ok);
    send_byte(8'hA5); send_byte(cmd); send_byte(spd); send_byte(chk);
    model_frame(cmd, spd, chk, ok);
  endtask

  // Waits for a period boundary to pass, then counts high samples over one
  // full 256-clk period of both outputs.
  task automatic measure_duty(output int hl, output int hr);
    hl = 0; hr = 0;
    idle(257);
    for (int i = 0; i < 256; i++) begin
      tick();
      hl += int'(pwm_l); hr += int'(pwm_r);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    idle(2);
    checks++;
    if ({motor_l, motor_r, pwm_l, pwm_r, LED, cmd_ok, frame_err, wdt_expired} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ml=%b mr=%b pl=%b pr=%b led=%h ok=%b err=%b wdt=%b, required all zero",
               motor_l, motor_r, pwm_l, pwm_r, LED, cmd_ok, frame_err, wdt_expired);
    end
    checks++;
    if (fsm_state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d required 0", fsm_state);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_fwd();
    logic ok; int hl, hr;
    send_frame(8'h01, 8'h80, 8'h81, ok);
    checks++;
    if ({cmd_ok, frame_err, motor_l, motor_r, LED} !== {1'b1, 1'b0, 4'b1010, 8'h01}) begin
      errors++;
      $display("FAIL fwd_accept: got ok=%b err=%b ml=%b mr=%b led=%h required ok=1 err=0 ml=10 mr=10 led=01",
               cmd_ok, frame_err, motor_l, motor_r, LED);
    end
    tick();
    checks++;
    if (cmd_ok !== 1'b0) begin
      errors++; $display("FAIL fwd_ok_pulse: got cmd_ok=%b required 0", cmd_ok);
    end
    measure_duty(hl, hr);
    checks++;
    if (hl != 128 || hr != 128) begin
      errors++; $display("FAIL fwd_duty: got l=%0d r=%0d required 128/256", hl, hr);
    end
  endtask

  task automatic test_spin_stop();
    logic ok; int hl, hr;
    send_frame(8'h03, 8'hFF, 8'hFC, ok);
    checks++;
    if ({cmd_ok, motor_l, motor_r, LED} !== {1'b1, 4'b0110, 8'h03}) begin
      errors++;
      $display("FAIL spin_l_accept: got ok=%b ml=%b mr=%b led=%h required ok=1 ml=01 mr=10 led=03",
               cmd_ok, motor_l, motor_r, LED);
    end
    measure_duty(hl, hr);
    checks++;
    if (hl != 255 || hr != 255) begin
      errors++; $display("FAIL spin_l_duty: got l=%0d r=%0d required 255/256", hl, hr);
    end
    send_frame(8'h00, 8'hFF, 8'hFF, ok);
    checks++;
    if ({cmd_ok, motor_l, motor_r, LED, pwm_l, pwm_r} !== {1'b1, 4'b0000, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL stop_accept: got ok=%b ml=%b mr=%b led=%h pl=%b pr=%b required ok=1 ml=00 mr=00 led=00 pwm=0",
               cmd_ok, motor_l, motor_r, LED, pwm_l, pwm_r);
    end
    measure_duty(hl, hr);
    checks++;
    if (hl != 0 || hr != 0) begin
      errors++; $display("FAIL stop_duty: got l=%0d r=%0d required 0/256", hl, hr);
    end
  endtask

  task automatic test_bad_frames();
    logic ok; int err_seen;
    send_frame(8'h01, 8'h80, 8'h81, ok);
    send_frame(8'h01, 8'h80, 8'h80, ok);
    checks++;
    if ({frame_err, cmd_ok, motor_l, motor_r, LED} !== {1'b1, 1'b0, 4'b1010, 8'h01}) begin
      errors++;
      $display("FAIL bad_chk: got err=%b ok=%b ml=%b mr=%b led=%h required err=1 ok=0 ml=10 mr=10 led=01",
               frame_err, cmd_ok, motor_l, motor_r, LED);
    end
    tick();
    send_frame(8'h07, 8'h10, 8'h17, ok);
    checks++;
    if ({frame_err, cmd_ok, motor_l, motor_r, LED} !== {1'b1, 1'b0, 4'b1010, 8'h01}) begin
      errors++;
      $display("FAIL bad_cmd: got err=%b ok=%b ml=%b mr=%b led=%h required err=1 ok=0 ml=10 mr=10 led=01",
               frame_err, cmd_ok, motor_l, motor_r, LED);
    end
    tick();
    err_seen = 0;
    send_byte(8'h11); err_seen += int'(frame_err);
    send_byte(8'h22); err_seen += int'(frame_err);
    tick();           err_seen += int'(frame_err);
    checks++;
    if (err_seen != 0) begin
      errors++; $display("FAIL garbage_err: got %0d frame_err samples required 0", err_seen);
    end
    send_frame(8'h02, 8'h40, 8'h42, ok);
    checks++;
    if ({cmd_ok, frame_err, motor_l, motor_r, LED} !== {1'b1, 1'b0, 4'b0101, 8'h02}) begin
      errors++;
      $display("FAIL after_garbage: got ok=%b err=%b ml=%b mr=%b led=%h required ok=1 err=0 ml=01 mr=01 led=02",
               cmd_ok, frame_err, motor_l, motor_r, LED);
    end
  endtask

  task automatic test_gap_timeout();
    logic ok; int err_seen;
    send_byte(8'hA5); send_byte(8'h01);
    err_seen = 0;
    for (int i = 0; i < GAP; i++) begin
      tick(); err_seen += int'(frame_err);
    end
    checks++;
    if (err_seen != 0) begin
      errors++; $display("FAIL gap_early: got %0d frame_err samples before expiry required 0", err_seen);
    end
    tick();
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("FAIL gap_expiry: got frame_err=%b required 1", frame_err);
    end
    tick();
    checks++;
    if (frame_err !== 1'b0 || {motor_l, motor_r, LED} !== {4'b0101, 8'h02}) begin
      errors++;
      $display("FAIL gap_after: got err=%b ml=%b mr=%b led=%h required err=0 ml=01 mr=01 led=02",
               frame_err, motor_l, motor_r, LED);
    end
    send_frame(8'h01, 8'h80, 8'h81, ok);
    checks++;
    if ({cmd_ok, motor_l, motor_r, LED} !== {1'b1, 4'b1010, 8'h01}) begin
      errors++;
      $display("FAIL gap_recover: got ok=%b ml=%b mr=%b led=%h required ok=1 ml=10 mr=10 led=01",
               cmd_ok, motor_l, motor_r, LED);
    end
  endtask

  // A byte arriving on exactly the clk the gap would expire is kept.
  task automatic test_gap_boundary();
    logic ok; int err_seen;
    send_byte(8'hA5); send_byte(8'h03);
    idle(GAP);
    err_seen = 0;
    send_byte(8'hFF); err_seen += int'(frame_err);
    send_byte(8'hFC); err_seen += int'(frame_err);
    model_frame(8'h03, 8'hFF, 8'hFC, ok);
    checks++;
    if (err_seen != 0 || {cmd_ok, motor_l, motor_r, LED} !== {1'b1, 4'b0110, 8'h03}) begin
      errors++;
      $display("FAIL gap_tie: got errs=%0d ok=%b ml=%b mr=%b led=%h required errs=0 ok=1 ml=01 mr=10 led=03",
               err_seen, cmd_ok, motor_l, motor_r, LED);
    end
  endtask

  task automatic test_watchdog();
    logic ok; int hl, hr;
    send_frame(8'h02, 8'h40, 8'h42, ok);
    idle(WDT - 1);
    checks++;
    if ({wdt_expired, motor_l, motor_r} !== {1'b0, 4'b0101}) begin
      errors++;
      $display("FAIL wdt_early: got wdt=%b ml=%b mr=%b required wdt=0 ml=01 mr=01", wdt_expired, motor_l, motor_r);
    end
    tick();
    checks++;
    if ({wdt_expired, motor_l, motor_r, pwm_l, pwm_r, LED} !== {1'b1, 4'b0000, 2'b00, 8'h02}) begin
      errors++;
      $display("FAIL wdt_expiry: got wdt=%b ml=%b mr=%b pl=%b pr=%b led=%h required wdt=1 motors 00 pwm 0 led=02",
               wdt_expired, motor_l, motor_r, pwm_l, pwm_r, LED);
    end
    measure_duty(hl, hr);
    checks++;
    if (hl != 0 || hr != 0 || wdt_expired !== 1'b1) begin
      errors++; $display("FAIL wdt_duty: got l=%0d r=%0d wdt=%b required 0 0 1", hl, hr, wdt_expired);
    end
    send_frame(8'h01, 8'h80, 8'h81, ok);
    checks++;
    if ({wdt_expired, cmd_ok, motor_l, motor_r, LED} !== {1'b0, 1'b1, 4'b1010, 8'h01}) begin
      errors++;
      $display("FAIL wdt_clear: got wdt=%b ok=%b ml=%b mr=%b led=%h required wdt=0 ok=1 ml=10 mr=10 led=01",
               wdt_expired, cmd_ok, motor_l, motor_r, LED);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic ok; int flags;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h20);
    reset = 1'b0;
    #1;
    checks++;
    if ({motor_l, motor_r, pwm_l, pwm_r, LED, cmd_ok, frame_err, wdt_expired} !== 17'd0) begin
      errors++;
      $display("FAIL async_reset: got ml=%b mr=%b pl=%b pr=%b led=%h ok=%b err=%b wdt=%b required all zero",
               motor_l, motor_r, pwm_l, pwm_r, LED, cmd_ok, frame_err, wdt_expired);
    end
    idle(3);
    reset = 1'b1;
    model_reset();
    flags = 0;
    send_byte(8'h24); flags += int'(frame_err) + int'(cmd_ok);
    tick();           flags += int'(frame_err) + int'(cmd_ok);
    checks++;
    if (flags != 0 || {motor_l, motor_r, LED} !== 12'd0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL leftover_chk: got pulses=%0d ml=%b mr=%b led=%h state=%0d required 0, zero outputs, state 0",
               flags, motor_l, motor_r, LED, fsm_state);
    end
    send_frame(8'h04, 8'h20, 8'h24, ok);
    checks++;
    if ({cmd_ok, motor_l, motor_r, LED} !== {1'b1, 4'b1001, 8'h04}) begin
      errors++;
      $display("FAIL post_reset_frame: got ok=%b ml=%b mr=%b led=%h required ok=1 ml=10 mr=01 led=04",
               cmd_ok, motor_l, motor_r, LED);
    end
  endtask

  task automatic test_random();
    logic [7:0] cmd, spd, chk;
    logic [W-1:0] exp_v, got_v;
    logic ok;
    int kind, hl, hr, err_seen;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 3);
      spd = 8'($urandom_range(0, 255));
      cmd = 8'($urandom_range(0, 4));
      if (kind == 2) cmd = 8'($urandom_range(5, 255));
      chk = cmd ^ spd;
      if (kind == 1) chk = chk ^ 8'($urandom_range(1, 255));
      idle($urandom_range(0, 10));
      if (kind == 3) begin
        err_seen = 0;
        for (int g = 0; g < 2; g++) begin
          rx_data = 8'($urandom_range(0, 255));
          if (rx_data == 8'hA5) rx_data = 8'h5A;
          rx_valid = 1'b1; tick(); rx_valid = 1'b0;
          err_seen += int'(frame_err);
        end
        checks++;
        if (err_seen != 0) begin
          errors++; $display("FAIL rnd_garbage %0d: got %0d frame_err samples required 0", f, err_seen);
        end
      end
      send_byte(8'hA5);
      idle($urandom_range(0, 15));
      send_byte(cmd);
      idle($urandom_range(0, 15));
      send_byte(spd);
      idle($urandom_range(0, 15));
      send_byte(chk);
      model_frame(cmd, spd, chk, ok);
      exp_q.push_back({ok, !ok, m_ml, m_mr, m_led, m_wdt});
      got_v = {cmd_ok, frame_err, motor_l, motor_r, LED, wdt_expired};
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL rnd_frame %0d (%h %h %h): got ok/err/ml/mr/led/wdt=%b required %b",
                 f, cmd, spd, chk, got_v, exp_v);
      end
      tick();
      checks++;
      if ({cmd_ok, frame_err} !== 2'b00) begin
        errors++; $display("FAIL rnd_pulse %0d: got ok=%b err=%b required 0 0", f, cmd_ok, frame_err);
      end
    end
    cmd = 8'($urandom_range(1, 4));
    spd = 8'($urandom_range(0, 255));
    send_frame(cmd, spd, cmd ^ spd, ok);
    measure_duty(hl, hr);
    model_wdt();
    checks++;
    if (hl != int'(m_duty) || hr != int'(m_duty)) begin
      errors++; $display("FAIL rnd_duty: got l=%0d r=%0d required %0d", hl, hr, m_duty);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fwd();
    test_spin_stop();
    test_bad_frames();
    test_gap_timeout();
    test_gap_boundary();
    test_watchdog();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL sim_timeout: simulation did not complete within 5 ms");
    $fatal(1);
  end

endmodule

// File: doc/car_cmd_ctrl.md
Name: car_cmd_ctrl

Overview:
- Downstream consumer of the UART receiver (4800 baud, 8N1, 125 MHz clk) that runs the car.
- Parses received bytes into 4-byte command frames, validates the checksum, and drives H-bridge direction pins and PWM enables for the left and right motors.
- A link watchdog stops the car when no valid frame arrives for too long.

Parameters:
- PWM_PRESC, 49: prescaler terminal count; pwm tick every PWM_PRESC+1 clks (≈9.77 kHz PWM with 8-bit counter).
- GAP_CYC, 520800: max clks between bytes inside a frame (≈2 byte times at 4800 baud).
- WDT_CYC, 62500000: clks without a valid frame before forced stop (500 ms).

Ports:
- clk  in  1  system clock, 125 MHz
- reset  in  1  asynchronous, active-low reset (0 = reset)
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  one-clk strobe per received byte; may assert on consecutive clks
- motor_l  out  2  left H-bridge {in1,in2}: 10 fwd, 01 back, 00 stop
- motor_r  out  2  right H-bridge, same encoding
- pwm_l  out  1  left enable PWM
- pwm_r  out  1  right enable PWM
- LED  out  8  cmd byte of last accepted frame
- cmd_ok  out  1  one-clk pulse per accepted frame
- frame_err  out  1  one-clk pulse on checksum, bad-cmd or gap error
- wdt_expired  out  1  level; high while watchdog stop is in force

Behaviour:
- Reset values (reset=0, async):
  - motor_l=motor_r=00, pwm_l=pwm_r=0, LED=0x00.
  - cmd_ok=frame_err=0, wdt_expired=0.
  - FSM in S_HDR; all counters 0; duty registers 0.
- Frame format: 0xA5, CMD, SPD, CHK, where CHK = CMD ^ SPD.
- FSM:
  - S_HDR: rx_valid with byte 0xA5 -> S_CMD. Any other byte is silently dropped; no error.
  - S_CMD: latch CMD -> S_SPD.
  - S_SPD: latch SPD -> S_CHK.
  - S_CHK: always -> S_HDR.
  - Inside S_CMD/S_SPD/S_CHK, 0xA5 is ordinary data; no resync.
- Gap timer:
  - Cleared on every rx_valid; counts while FSM is not S_HDR.
  - On reaching GAP_CYC: FSM -> S_HDR and frame_err pulses. Partial frame discarded; outputs unchanged.
- Checksum-byte handling (the clk with rx_valid in S_CHK):
  - CHK mismatch -> frame_err pulse, nothing updated.
  - CMD > 0x04 -> frame_err pulse, nothing updated.
  - Otherwise accept. On the next edge (1-clk latency): motor_l/motor_r updated, LED=CMD, target duty=SPD, cmd_ok pulse, watchdog cleared, wdt_expired=0.
- CMD decode (motor_l / motor_r):
  - 0x00 stop: 00/00, target duty forced to 0.
  - 0x01 fwd: 10/10.
  - 0x02 back: 01/01.
  - 0x03 spin left: 01/10.
  - 0x04 spin right: 10/01.
- PWM:
  - Prescaler counts 0..PWM_PRESC; an 8-bit pwm_cnt advances on each wrap.
  - pwm_x = (pwm_cnt < duty_x). duty 0 -> constant 0; duty 255 -> high 255/256.
  - Effective duty loads from target only when pwm_cnt wraps 255->0, so there are no mid-period glitches.
  - Exception: a forced stop (cmd 0x00 or watchdog) zeroes effective duty and pwm outputs on the next clk.
  - Both motors share one duty value.
- Watchdog:
  - Counter increments every clk, saturates at WDT_CYC.
  - On reaching WDT_CYC: motor_l=motor_r=00, duties=0, wdt_expired=1.
  - LED retained.
  - Only an accepted frame clears it.
- Simultaneous events:
  - Accept and watchdog expiry on the same clk: accept wins (watchdog cleared, no stop).
  - Gap timeout and rx_valid on the same clk: rx_valid wins; the byte is processed and the gap timer cleared.
- Reset mid-frame: everything returns to reset values immediately; the next frame starts clean from S_HDR.

Decomposition:
- Package car_pkg:
  - Frame header 0xA5.
  - CMD codes 0x00..0x04.
  - Motor encodings MOT_FWD=2'b10, MOT_BACK=2'b01, MOT_STOP=2'b00.
  - FSM state enum {S_HDR,S_CMD,S_SPD,S_CHK}.
- Sub-module car_pwm_gen: prescaler + 8-bit counter + wrap-aligned duty load + force-zero input. Instantiated once; output feeds both pwm_l and pwm_r.
- Parser, decode and watchdog stay in the top.

Test Plan:
- Sim overrides: PWM_PRESC=0, GAP_CYC=200, WDT_CYC=2000; bytes delivered as rx_valid strobes.
- Frame A5 01 80 81 -> cmd_ok 1 clk after last strobe; motor_l=motor_r=10, LED=0x01. After the next wrap, pwm_l high for 128 of every 256 clks.
- Frame A5 03 FF FC -> motor_l=01, motor_r=10, duty 255 after wrap. Then A5 00 FF FF -> 00/00, pwm low the next clk, LED=0x00.
- Bad frames:
  - A5 01 80 80 -> frame_err pulse, outputs unchanged.
  - A5 07 10 17 -> frame_err pulse, outputs unchanged.
  - Garbage 11 22 before A5 -> no frame_err.
- A5 01 then 201 idle clks -> frame_err at gap expiry. A following valid frame is accepted normally.
- Accept A5 02 40 42, then 2000 idle clks -> wdt_expired=1, motors 00, pwm 0. Next valid frame clears wdt_expired.
- Assert reset for 3 clks between the SPD and CHK strobes -> all outputs at reset values. The leftover CHK byte is dropped silently.
